autoplay_scheduler: RTL

Sequences the cube's configuration outputs when the cube is in autoplay mode (mode 4'h3). It takes the stored mode, brightness and animation selection, and the stream of UART configuration bytes. It cycles through a user-maskable playlist of animations, dwelling a fixed number of frames on each and cross-fading brightness at every switch. While a fade is in progress it holds the mode register, so a UART mode change cannot land mid-transition. It sits between the configuration registers and the frame renderer. Outside mode 3 it passes the configured brightness and animation straight through.

---
 rtl/cube_cfg_pkg.sv | 19 +
 rtl/next_anim_picker.sv | 31 +++
 rtl/autoplay_scheduler.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cube_cfg_pkg.sv
// Shared definitions for the cube configuration path: the autoplay
// scheduler state encoding and the configuration byte indices.
package cube_cfg_pkg;

  // Scheduler states; the encoding is visible on the sched_state debug port.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DWELL    = 2'd1,
    ST_FADE_OUT = 2'd2,
    ST_FADE_IN  = 2'd3
  } sched_state_t;

  localparam logic [3:0] MODE_AUTOPLAY = 4'h3;
  localparam logic [3:0] IDX_MASK_LO   = 4'hB;
  localparam logic [3:0] IDX_MASK_HI   = 4'hC;

  localparam int NUM_ANIM = 8;

endpackage

// File: rtl/next_anim_picker.sv
// Rotate-priority search over the playlist mask: returns the first enabled
// animation after cur (wrapping), with cur itself checked last. When no bit
// is set the current animation is kept.
module next_anim_picker
  import cube_cfg_pkg::*;
(
  input  logic [7:0] mask,
  input  logic [2:0] cur,
  output logic [2:0] next,
  output logic       any_set
);

  logic [2:0] idx;
  logic       found;

  // Walk cur+1 .. cur+8 (mod 8) and keep the first enabled slot.
  always_comb begin
    next    = cur;
    any_set = |mask;
    found   = 1'b0;
    idx     = cur;
    for (int i = 1; i <= NUM_ANIM; i++) begin
      idx = cur + i[2:0];
      if (!found && mask[idx]) begin
        next  = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/autoplay_scheduler.sv
// Autoplay scheduler: in autoplay mode, cycles through the masked playlist,
// dwelling a fixed number of frames per animation and cross-fading the
// brightness at each switch. Outside autoplay it passes the configured
// animation and brightness through with one cycle of latency.
module autoplay_scheduler
  import cube_cfg_pkg::*;
#(
  parameter int DWELL_FRAMES     = 240,
  parameter int FADE_STEP_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] uart_in,
  input  logic       uart_valid,
  input  logic [3:0] mode,
  input  logic [3:0] brightness_cfg,
  input  logic [3:0] anim_sel_cfg,
  input  logic       frame_done,
  output logic [3:0] anim_sel,
  output logic [3:0] brightness,
  output logic       stall_mode_change,
  output logic [1:0] sched_state
);

  localparam int DW_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam int SW_W = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_FRAMES - 1);
  localparam logic [SW_W-1:0] STEP_LAST  = SW_W'(FADE_STEP_FRAMES - 1);

  sched_state_t    state, state_n;
  logic [7:0]      mask, mask_n;
  logic [2:0]      cur, cur_n;
  logic [3:0]      bright, bright_n;
  logic [DW_W-1:0] dwell_cnt, dwell_n;
  logic [SW_W-1:0] step_cnt, step_n;
  logic [3:0]      anim_n, bright_out_n;
  logic            stall_n;
  logic [2:0]      pick_next;
  logic            pick_any;
  logic            autoplay;
  logic            cfg_unused;

  // Only animations 0-7 exist, so the top bit of the configured index is dropped.
  assign cfg_unused  = anim_sel_cfg[3];
  assign autoplay    = (mode == MODE_AUTOPLAY);
  assign sched_state = state;

  // The search always sees the mask as it stood before this cycle's write.
  next_anim_picker u_picker (
    .mask    (mask),
    .cur     (cur),
    .next    (pick_next),
    .any_set (pick_any)
  );

  // State, datapath and output registers; everything returns to its reset value at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_IDLE;
      mask              <= 8'hFF;
      cur               <= 3'd1;
      bright            <= 4'hF;
      dwell_cnt         <= '0;
      step_cnt          <= '0;
      anim_sel          <= 4'h1;
      brightness        <= 4'hF;
      stall_mode_change <= 1'b0;
    end else begin
      state             <= state_n;
      mask              <= mask_n;
      cur               <= cur_n;
      bright            <= bright_n;
      dwell_cnt         <= dwell_n;
      step_cnt          <= step_n;
      anim_sel          <= anim_n;
      brightness        <= bright_out_n;
      stall_mode_change <= stall_n;
    end
  end

  // Next-state, mask update and registered-output values; leaving autoplay always wins.
  always_comb begin
    state_n  = state;
    mask_n   = mask;
    cur_n    = cur;
    bright_n = bright;
    dwell_n  = dwell_cnt;
    step_n   = step_cnt;

    if (uart_valid) begin
      case (uart_in[7:4])
        IDX_MASK_LO: mask_n[3:0] = uart_in[3:0];
        IDX_MASK_HI: mask_n[7:4] = uart_in[3:0];
        default: ;
      endcase
    end

    case (state)
      ST_IDLE: begin
        if (autoplay) begin
          cur_n   = anim_sel_cfg[2:0];
          bright_n = brightness_cfg;
          dwell_n = '0;
          step_n  = '0;
          state_n = ST_DWELL;
        end
      end
      ST_DWELL: begin
        if (!autoplay) begin
          state_n = ST_IDLE;
        end else if (frame_done) begin
          if (dwell_cnt == DWELL_LAST) begin
            dwell_n = '0;
            step_n  = '0;
            state_n = ST_FADE_OUT;
          end else begin
            dwell_n = dwell_cnt + 1'b1;
          end
        end
      end
      ST_FADE_OUT: begin
        if (!autoplay) begin
          state_n = ST_IDLE;
        end else if (bright == 4'd0) begin
          if (pick_any) cur_n = pick_next;
          step_n  = '0;
          state_n = ST_FADE_IN;
        end else if (frame_done) begin
          if (step_cnt == STEP_LAST) begin
            step_n   = '0;
            bright_n = bright - 4'd1;
          end else begin
            step_n = step_cnt + 1'b1;
          end
        end
      end
      ST_FADE_IN: begin
        if (!autoplay) begin
          state_n = ST_IDLE;
        end else if (bright >= brightness_cfg) begin
          dwell_n = '0;
          step_n  = '0;
          state_n = ST_DWELL;
        end else if (frame_done) begin
          if (step_cnt == STEP_LAST) begin
            step_n   = '0;
            bright_n = bright + 4'd1;
          end else begin
            step_n = step_cnt + 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (state_n == ST_IDLE) begin
      anim_n       = {1'b0, anim_sel_cfg[2:0]};
      bright_out_n = brightness_cfg;
    end else begin
      anim_n       = {1'b0, cur_n};
      bright_out_n = bright_n;
    end
    stall_n = (state_n == ST_FADE_OUT) || (state_n == ST_FADE_IN);
  end

endmodule
